// File: rtl/tluh_pkg.sv
// TileLink-UH encodings shared by the initiator and its source allocator,
// plus the byte-lane mask helper used for non-partial A requests.
package tluh_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_ARITHMETIC_DATA  = 3'd2,
    A_LOGICAL_DATA     = 3'd3,
    A_GET              = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic [2:0] {
    LOGIC_XOR  = 3'd0,
    LOGIC_OR   = 3'd1,
    LOGIC_AND  = 3'd2,
    LOGIC_SWAP = 3'd3
  } logical_param_e;

  // Lanes covered by a naturally sized access; lanes shifted past bit 3 drop off.
  function automatic logic [3:0] gen_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << addr_lo;
  endfunction

endpackage

// File: rtl/tluh_source_alloc.sv
// Source-ID table: pending/expect-data bits per ID and a lowest-free picker
// that only looks at the registered bitmap.
module tluh_source_alloc #(
  parameter int TL_RS           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       tlm_clock_i,
  input  logic                       tlm_reset_i,
  input  logic                       alloc_en,
  input  logic                       alloc_expect_data,
  output logic [TL_RS-1:0]           alloc_id,
  output logic                       any_free,
  input  logic                       free_en,
  input  logic [TL_RS-1:0]           free_id,
  output logic [MAX_OUTSTANDING-1:0] pending,
  output logic [MAX_OUTSTANDING-1:0] expect_data
);

  always_comb begin
    alloc_id = '0;
    any_free = 1'b0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!pending[i]) begin
        alloc_id = TL_RS'(i);
        any_free = 1'b1;
      end
    end
  end

  // An ID freed this cycle is still pending in the bitmap the picker sees,
  // so it cannot be handed out again until the following cycle.
  always_ff @(posedge tlm_clock_i) begin
    if (tlm_reset_i) begin
      pending     <= '0;
      expect_data <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (free_en && free_id == TL_RS'(i)) pending[i] <= 1'b0;
        if (alloc_en && alloc_id == TL_RS'(i)) begin
          pending[i]     <= 1'b1;
          expect_data[i] <= alloc_expect_data;
        end
      end
    end
  end

endmodule

// File: rtl/tluh_initiator.sv
// TL-UH initiator: registers core requests onto the A channel with a tracked
// source ID and returns matching D beats to the core through a one-entry buffer.
module tluh_initiator
  import tluh_pkg::*;
#(
  parameter int TL_RS           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             tlm_clock_i,
  input  logic             tlm_reset_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_opcode,
  input  logic [2:0]       req_param,
  input  logic [1:0]       req_size,
  input  logic [31:0]      req_address,
  input  logic [31:0]      req_data,
  input  logic [3:0]       req_mask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TL_RS-1:0] resp_source,
  output logic [31:0]      resp_data,
  output logic             resp_error,
  output logic [2:0]       tlm_a_opcode,
  output logic [2:0]       tlm_a_param,
  output logic [3:0]       tlm_a_size,
  output logic [TL_RS-1:0] tlm_a_source,
  output logic [31:0]      tlm_a_address,
  output logic [3:0]       tlm_a_mask,
  output logic [31:0]      tlm_a_data,
  output logic             tlm_a_corrupt,
  output logic             tlm_a_valid,
  input  logic             tlm_a_ready,
  input  logic [2:0]       tlm_d_opcode,
  input  logic [1:0]       tlm_d_param,
  input  logic [3:0]       tlm_d_size,
  input  logic [TL_RS-1:0] tlm_d_source,
  input  logic             tlm_d_denied,
  input  logic [31:0]      tlm_d_data,
  input  logic             tlm_d_corrupt,
  input  logic             tlm_d_valid,
  output logic             tlm_d_ready,
  output logic             busy,
  output logic             err_unexpected
);

  logic                       any_free;
  logic                       req_fire;
  logic                       a_fire;
  logic                       d_fire;
  logic                       d_pend;
  logic                       d_expd;
  logic                       d_expected;
  logic [2:0]                 d_want;
  logic [TL_RS-1:0]           alloc_id;
  logic [MAX_OUTSTANDING-1:0] pending;
  logic [MAX_OUTSTANDING-1:0] expect_data;
  logic                       unused_d_fields;

  assign req_ready   = any_free & (~tlm_a_valid | tlm_a_ready);
  assign req_fire    = req_valid & req_ready;
  assign a_fire      = tlm_a_valid & tlm_a_ready;
  assign tlm_d_ready = ~resp_valid | resp_ready;
  assign d_fire      = tlm_d_valid & tlm_d_ready;
  assign busy        = |pending;

  assign unused_d_fields = ^{tlm_d_param, tlm_d_size};

  tluh_source_alloc #(
    .TL_RS           (TL_RS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_alloc (
    .tlm_clock_i       (tlm_clock_i),
    .tlm_reset_i       (tlm_reset_i),
    .alloc_en          (req_fire),
    .alloc_expect_data ((req_opcode == A_GET) || (req_opcode == A_LOGICAL_DATA)),
    .alloc_id          (alloc_id),
    .any_free          (any_free),
    .free_en           (d_fire & d_expected),
    .free_id           (tlm_d_source),
    .pending           (pending),
    .expect_data       (expect_data)
  );

  always_comb begin
    d_pend = 1'b0;
    d_expd = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tlm_d_source == TL_RS'(i)) begin
        d_pend = pending[i];
        d_expd = expect_data[i];
      end
    end
  end

  assign d_want     = d_expd ? 3'(D_ACCESS_ACK_DATA) : 3'(D_ACCESS_ACK);
  assign d_expected = d_pend & (tlm_d_opcode == d_want);

  always_ff @(posedge tlm_clock_i) begin
    if (tlm_reset_i) begin
      tlm_a_valid   <= 1'b0;
      tlm_a_opcode  <= '0;
      tlm_a_param   <= '0;
      tlm_a_size    <= '0;
      tlm_a_source  <= '0;
      tlm_a_address <= '0;
      tlm_a_mask    <= '0;
      tlm_a_data    <= '0;
      tlm_a_corrupt <= 1'b0;
    end else if (req_fire) begin
      tlm_a_valid   <= 1'b1;
      tlm_a_opcode  <= req_opcode;
      tlm_a_param   <= (req_opcode == A_LOGICAL_DATA) ? req_param : 3'd0;
      tlm_a_size    <= {2'b00, req_size};
      tlm_a_source  <= alloc_id;
      tlm_a_address <= req_address;
      tlm_a_mask    <= (req_opcode == A_PUT_PARTIAL_DATA) ? req_mask
                                                          : gen_mask(req_size, req_address[1:0]);
      tlm_a_data    <= req_data;
      tlm_a_corrupt <= 1'b0;
    end else if (a_fire) begin
      tlm_a_valid <= 1'b0;
    end
  end

  // Unexpected beats are swallowed: no response, table untouched, error sticks.
  always_ff @(posedge tlm_clock_i) begin
    if (tlm_reset_i) begin
      resp_valid     <= 1'b0;
      resp_source    <= '0;
      resp_data      <= '0;
      resp_error     <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (resp_valid && resp_ready) resp_valid <= 1'b0;
      if (d_fire && d_expected) begin
        resp_valid  <= 1'b1;
        resp_source <= tlm_d_source;
        resp_data   <= d_expd ? tlm_d_data : 32'd0;
        resp_error  <= tlm_d_denied | tlm_d_corrupt;
      end
      if (d_fire && !d_expected) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tluh_initiator.sv
// Scoreboard bench for tluh_initiator: directed scenarios, then randomized
// traffic checked against a source-table reference model kept in the bench.
module tb_tluh_initiator;
  localparam int RS = 4;
  localparam int MO = 4;

  logic          tlm_clock_i = 1'b0;
  logic          tlm_reset_i = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_opcode = '0;
  logic [2:0]    req_param = '0;
  logic [1:0]    req_size = '0;
  logic [31:0]   req_address = '0;
  logic [31:0]   req_data = '0;
  logic [3:0]    req_mask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [RS-1:0] resp_source;
  logic [31:0]   resp_data;
  logic          resp_error;
  logic [2:0]    tlm_a_opcode;
  logic [2:0]    tlm_a_param;
  logic [3:0]    tlm_a_size;
  logic [RS-1:0] tlm_a_source;
  logic [31:0]   tlm_a_address;
  logic [3:0]    tlm_a_mask;
  logic [31:0]   tlm_a_data;
  logic          tlm_a_corrupt;
  logic          tlm_a_valid;
  logic          tlm_a_ready = 1'b1;
  logic [2:0]    tlm_d_opcode = '0;
  logic [1:0]    tlm_d_param = '0;
  logic [3:0]    tlm_d_size = '0;
  logic [RS-1:0] tlm_d_source = '0;
  logic          tlm_d_denied = 1'b0;
  logic [31:0]   tlm_d_data = '0;
  logic          tlm_d_corrupt = 1'b0;
  logic          tlm_d_valid = 1'b0;
  logic          tlm_d_ready;
  logic          busy;
  logic          err_unexpected;

  always #5 tlm_clock_i = ~tlm_clock_i;

  tluh_initiator #(.TL_RS(RS), .MAX_OUTSTANDING(MO)) dut (
    .tlm_clock_i(tlm_clock_i), .tlm_reset_i(tlm_reset_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_param(req_param), .req_size(req_size), .req_address(req_address),
    .req_data(req_data), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_source(resp_source),
    .resp_data(resp_data), .resp_error(resp_error),
    .tlm_a_opcode(tlm_a_opcode), .tlm_a_param(tlm_a_param), .tlm_a_size(tlm_a_size),
    .tlm_a_source(tlm_a_source), .tlm_a_address(tlm_a_address), .tlm_a_mask(tlm_a_mask),
    .tlm_a_data(tlm_a_data), .tlm_a_corrupt(tlm_a_corrupt), .tlm_a_valid(tlm_a_valid),
    .tlm_a_ready(tlm_a_ready),
    .tlm_d_opcode(tlm_d_opcode), .tlm_d_param(tlm_d_param), .tlm_d_size(tlm_d_size),
    .tlm_d_source(tlm_d_source), .tlm_d_denied(tlm_d_denied), .tlm_d_data(tlm_d_data),
    .tlm_d_corrupt(tlm_d_corrupt), .tlm_d_valid(tlm_d_valid), .tlm_d_ready(tlm_d_ready),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_t;
  typedef struct packed {
    logic [3:0]  src;
    logic [31:0] data;
    logic        err;
  } r_t;
  typedef struct packed {
    logic [3:0] src;
    logic       expd;
  } p_t;

  a_t   a_exp[$];
  r_t   r_exp[$];
  p_t   rsp_list[$];
  logic model_pend[16];
  logic model_expd[16];
  logic model_err = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   a_fires = 0;
  bit   started = 0;
  bit   ready_rand = 0;
  bit   req_done = 0;
  logic rr_force = 1'b1;
  logic ar_force = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic model_any_free();
    logic f = 1'b0;
    for (int i = 0; i < MO; i++) if (!model_pend[i]) f = 1'b1;
    return f;
  endfunction

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < MO; i++) if (model_pend[i]) b = 1'b1;
    return b;
  endfunction

  function automatic logic [3:0] lowest_free();
    logic [3:0] r = 4'd0;
    for (int i = MO - 1; i >= 0; i--) if (!model_pend[i]) r = 4'(i);
    return r;
  endfunction

  // Byte lanes touched by a 2**size byte access starting at addr[1:0].
  function automatic logic [3:0] ref_mask(input logic [2:0] op, input logic [1:0] sz,
                                          input logic [31:0] addr, input logic [3:0] m);
    int bytes;
    int v;
    if (op == 3'd1) return m;
    bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = ((1 << bytes) - 1) << addr[1:0];
    return 4'(v);
  endfunction

  always @(posedge tlm_clock_i) begin
    #1;
    if (ready_rand) begin
      resp_ready  = 1'($urandom_range(0, 1));
      tlm_a_ready = ($urandom_range(0, 3) != 0);
    end else begin
      resp_ready  = rr_force;
      tlm_a_ready = ar_force;
    end
  end

  // Monitor: handshakes seen here fire on the coming rising edge.
  always @(negedge tlm_clock_i) begin
    a_t act_a;
    a_t e;
    r_t act_r;
    r_t r;
    if (tlm_reset_i) begin
      started = 1;
      for (int i = 0; i < 16; i++) begin
        model_pend[i] = 1'b0;
        model_expd[i] = 1'b0;
      end
      model_err = 1'b0;
      a_exp.delete();
      r_exp.delete();
      rsp_list.delete();
    end else if (started) begin
      chk("busy", 128'(busy), 128'(model_busy()));
      chk("err_unexpected", 128'(err_unexpected), 128'(model_err));
      if (!tlm_a_valid) chk("req_ready", 128'(req_ready), 128'(model_any_free()));
      if (req_valid && req_ready) begin
        e.src   = lowest_free();
        e.op    = req_opcode;
        e.param = (req_opcode == 3'd3) ? req_param : 3'd0;
        e.size  = {2'b00, req_size};
        e.addr  = req_address;
        e.mask  = ref_mask(req_opcode, req_size, req_address, req_mask);
        e.data  = req_data;
        a_exp.push_back(e);
        model_pend[e.src] = 1'b1;
        model_expd[e.src] = (req_opcode == 3'd4) || (req_opcode == 3'd3);
      end
      if (tlm_a_valid) begin
        if (a_exp.size() == 0) fail("a_spurious");
        else begin
          act_a = {tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source,
                   tlm_a_address, tlm_a_mask, tlm_a_data};
          chk("a_beat", 128'(act_a), 128'(a_exp[0]));
          chk("a_corrupt", 128'(tlm_a_corrupt), 128'(0));
          if (tlm_a_ready) begin
            a_fires++;
            rsp_list.push_back({a_exp[0].src, model_expd[a_exp[0].src]});
            void'(a_exp.pop_front());
          end
        end
      end
      if (tlm_d_valid && tlm_d_ready) begin
        if (model_pend[tlm_d_source] &&
            tlm_d_opcode == (model_expd[tlm_d_source] ? 3'd1 : 3'd0)) begin
          r.src  = tlm_d_source;
          r.data = (tlm_d_opcode == 3'd1) ? tlm_d_data : 32'd0;
          r.err  = tlm_d_denied | tlm_d_corrupt;
          r_exp.push_back(r);
          model_pend[tlm_d_source] = 1'b0;
        end else begin
          model_err = 1'b1;
        end
      end
      if (resp_valid && resp_ready) begin
        if (r_exp.size() == 0) fail("resp_spurious");
        else begin
          act_r = {resp_source, resp_data, resp_error};
          chk("resp", 128'(act_r), 128'(r_exp.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge tlm_clock_i);
    #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] msk);
    int n = 0;
    req_opcode = op; req_param = prm; req_size = sz;
    req_address = addr; req_data = dat; req_mask = msk;
    req_valid = 1'b1;
    @(negedge tlm_clock_i);
    while (!req_ready && n < 500) begin
      n++;
      @(negedge tlm_clock_i);
    end
    if (!req_ready) fail("req_timeout");
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_d(input logic [3:0] src, input logic [2:0] op, input logic [31:0] dat,
                        input logic den, input logic cor);
    int n = 0;
    tlm_d_source = src; tlm_d_opcode = op; tlm_d_data = dat;
    tlm_d_denied = den; tlm_d_corrupt = cor;
    tlm_d_valid = 1'b1;
    @(negedge tlm_clock_i);
    while (!tlm_d_ready && n < 500) begin
      n++;
      @(negedge tlm_clock_i);
    end
    if (!tlm_d_ready) fail("d_timeout");
    tick();
    tlm_d_valid = 1'b0;
  endtask

  task automatic respond_src(input logic [3:0] src, input logic [31:0] dat,
                             input logic den, input logic cor);
    int n = 0;
    int idx = -1;
    p_t p;
    while (idx < 0 && n < 100) begin
      foreach (rsp_list[i]) if (idx < 0 && rsp_list[i].src == src) idx = i;
      if (idx < 0) begin
        n++;
        tick();
      end
    end
    if (idx < 0) fail("respond_wait_timeout");
    else begin
      p = rsp_list[idx];
      rsp_list.delete(idx);
      send_d(src, p.expd ? 3'd1 : 3'd0, dat, den, cor);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || rsp_list.size() > 0) && n < 500) begin
      if (rsp_list.size() > 0) respond_src(rsp_list[0].src, $urandom, 1'b0, 1'b0);
      else tick();
      n++;
    end
    if (busy) fail("drain_timeout");
    repeat (2) tick();
  endtask

  task automatic do_reset();
    tlm_reset_i = 1'b1;
    repeat (2) tick();
    tlm_reset_i = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_fires;
    repeat (3) tick();
    tlm_reset_i = 1'b0;
    @(negedge tlm_clock_i);
    chk("rst_a_valid", 128'(tlm_a_valid), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err_unexpected), 128'(0));
    chk("rst_a_opcode", 128'(tlm_a_opcode), 128'(0));
    chk("rst_resp_data", 128'(resp_data), 128'(0));
    tick();

    // Get with delayed AccessAckData, then a byte PutFull at an odd address.
    send_req(3'd4, 3'd0, 2'd2, 32'h0000_BFF8, 32'h0, 4'h0);
    repeat (3) tick();
    respond_src(4'd0, 32'h1234_5678, 1'b0, 1'b0);
    send_req(3'd0, 3'd0, 2'd0, 32'h0000_1003, 32'h0000_00AB, 4'h0);
    respond_src(4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (3) tick();

    // Fill the table, confirm back-pressure, free source 2 and reuse it.
    for (int i = 0; i < MO; i++) send_req(3'd4, 3'd0, 2'd2, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
    req_opcode = 3'd4; req_address = 32'h200; req_valid = 1'b1;
    repeat (3) begin
      @(negedge tlm_clock_i);
      chk("full_req_ready", 128'(req_ready), 128'(0));
    end
    tick();
    req_valid = 1'b0;
    respond_src(4'd2, 32'hCAFE_0002, 1'b0, 1'b0);
    send_req(3'd4, 3'd0, 2'd2, 32'h204, 32'h0, 4'h0);
    drain();

    // A channel stalled for five cycles: beat held stable, fires once.
    ar_force = 1'b0;
    base_fires = a_fires;
    send_req(3'd1, 3'd0, 2'd2, 32'h2000, 32'h5A5A_A5A5, 4'b0101);
    repeat (5) begin
      @(negedge tlm_clock_i);
      chk("stall_a_valid", 128'(tlm_a_valid), 128'(1));
      chk("stall_no_fire", 128'(a_fires), 128'(base_fires));
    end
    ar_force = 1'b1;
    repeat (3) tick();
    chk("stall_one_fire", 128'(a_fires), 128'(base_fires + 1));
    send_req(3'd3, 3'd2, 2'd1, 32'h3002, 32'h0000_00F0, 4'h0);
    drain();

    // Unexpected beats: stray source while idle, then wrong opcode for a Get.
    send_d(4'd3, 3'd1, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge tlm_clock_i);
    chk("stray_err", 128'(err_unexpected), 128'(1));
    chk("stray_no_resp", 128'(resp_valid), 128'(0));
    tick();
    send_req(3'd4, 3'd0, 2'd2, 32'h4000, 32'h0, 4'h0);
    repeat (3) tick();
    send_d(4'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    @(negedge tlm_clock_i);
    chk("mismatch_busy", 128'(busy), 128'(1));
    chk("mismatch_no_resp", 128'(resp_valid), 128'(0));
    tick();
    drain();

    // Denied Put with the core stalling the response for two cycles.
    rr_force = 1'b0;
    send_req(3'd0, 3'd0, 2'd2, 32'h5000, 32'h7777_7777, 4'h0);
    respond_src(4'd0, 32'h0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge tlm_clock_i);
      chk("held_resp_valid", 128'(resp_valid), 128'(1));
      chk("held_resp_error", 128'(resp_error), 128'(1));
      chk("held_d_ready", 128'(tlm_d_ready), 128'(0));
    end
    rr_force = 1'b1;
    repeat (3) tick();
    chk("held_resp_taken", 128'(resp_valid), 128'(0));

    do_reset();
    @(negedge tlm_clock_i);
    chk("reset_clears_err", 128'(err_unexpected), 128'(0));
    tick();

    // Randomized traffic with random ready on both sides.
    ready_rand = 1;
    fork
      begin
        logic [2:0] ops[4];
        logic [2:0] op;
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd3; ops[3] = 3'd4;
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          op = ops[$urandom_range(0, 3)];
          send_req(op, 3'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   $urandom, $urandom, 4'($urandom));
        end
        req_done = 1;
      end
      begin
        int n = 0;
        while ((!req_done || busy || rsp_list.size() > 0) && n < 20000) begin
          if (rsp_list.size() > 0 && $urandom_range(0, 2) == 0) begin
            int k;
            p_t p;
            k = int'($urandom_range(0, rsp_list.size() - 1));
            p = rsp_list[k];
            rsp_list.delete(k);
            send_d(p.src, p.expd ? 3'd1 : 3'd0, $urandom,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
          end else begin
            tick();
          end
          n++;
        end
        if (n >= 20000) fail("random_responder_timeout");
      end
    join
    ready_rand = 0;
    repeat (4) tick();
    chk("random_idle_busy", 128'(busy), 128'(0));

    // Reset mid-transaction: a late D beat afterwards is unexpected.
    send_req(3'd4, 3'd0, 2'd2, 32'h6000, 32'h0, 4'h0);
    repeat (2) tick();
    do_reset();
    send_d(4'd0, 3'd1, 32'h9999_9999, 1'b0, 1'b0);
    @(negedge tlm_clock_i);
    chk("late_d_err", 128'(err_unexpected), 128'(1));
    chk("late_d_no_resp", 128'(resp_valid), 128'(0));
    tick();

    chk("a_queue_empty", 128'(a_exp.size()), 128'(0));
    chk("resp_queue_empty", 128'(r_exp.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
